piso_stream: RTL and testbench

Parametrised synchronous parallel-in/serial-out serializer with a valid/ready load handshake, bit-rate enable, selectable bit order and back-to-back word streaming. It sits between a parallel word producer and a single-wire serial link. It succeeds the fixed 4-bit PISO and adds these behaviours it lacks:
- width parameter
- handshake
- bit counter / FSM
- done indication

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_cell.sv | 29 ++
 rtl/piso_stream.sv | 117 +++++++++++
 tb/tb_piso_stream.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream serializer.
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } piso_state_t;

  // Counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_cell.sv
// One bit slice of the serializer shift register: load/shift/hold mux and a flop.
module piso_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic din_bit,
  input  logic shift_in,
  output logic q,
  output logic nxt
);

  // nxt is exported so the top can register the upcoming output bit in step with the shift.
  always_comb begin
    nxt = q;
    if (load)
      nxt = din_bit;
    else if (shift)
      nxt = shift_in;
  end

  always_ff @(posedge clk) begin
    if (rst)
      q <= 1'b0;
    else
      q <= nxt;
  end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with valid/ready load, bit-rate enable and back-to-back streaming.
module piso_stream
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW      = cnt_width(WIDTH);
  localparam int OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;

  piso_state_t      state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] shift_in;
  logic             last_bit;
  logic             load_fire;
  logic             advance;

  assign last_bit   = (cnt == CW'(1));
  assign load_ready = (state == IDLE) || ((state == SHIFT) && last_bit && shift_en);
  assign load_fire  = load_valid && load_ready;
  assign advance    = (state == SHIFT) && shift_en && (cnt > CW'(1));
  assign busy       = sout_valid;

  // Bit order is decided purely by which neighbour feeds each slice; the far end fills with 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (LSB_FIRST) begin : g_lsb
      if (i == WIDTH - 1) begin : g_end
        assign shift_in[i] = 1'b0;
      end else begin : g_mid
        assign shift_in[i] = shreg[i+1];
      end
    end else begin : g_msb
      if (i == 0) begin : g_end
        assign shift_in[i] = 1'b0;
      end else begin : g_mid
        assign shift_in[i] = shreg[i-1];
      end
    end

    piso_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .load     (load_fire),
      .shift    (advance),
      .din_bit  (din[i]),
      .shift_in (shift_in[i]),
      .q        (shreg[i]),
      .nxt      (shreg_nxt[i])
    );
  end

  // sout is registered from the slice that will sit at the output end after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sout       <= IDLE_LEVEL;
          sout_valid <= 1'b0;
          if (load_fire) begin
            state      <= SHIFT;
            cnt        <= CW'(WIDTH);
            sout       <= shreg_nxt[OUT_IDX];
            sout_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (!shift_en) begin
            sout <= shreg[OUT_IDX];
          end else if (!last_bit) begin
            cnt  <= cnt - CW'(1);
            sout <= shreg_nxt[OUT_IDX];
          end else begin
            done <= 1'b1;
            if (load_fire) begin
              cnt  <= CW'(WIDTH);
              sout <= shreg_nxt[OUT_IDX];
            end else begin
              state      <= IDLE;
              cnt        <= '0;
              sout       <= IDLE_LEVEL;
              sout_valid <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          sout       <= IDLE_LEVEL;
          sout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: an MSB-first (idle 0) and an LSB-first (idle 1) copy share stimulus.
module tb_piso_stream;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] din;
  logic       shift_en;

  logic load_ready, sout, sout_valid, busy, done;
  logic lsb_load_ready, lsb_sout, lsb_sout_valid, lsb_busy, lsb_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] seq_msb;
  logic [7:0] seq_lsb;
  logic [7:0] word;

  piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready), .din(din),
    .shift_en(shift_en), .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done)
  );

  piso_stream #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lsb_load_ready), .din(din),
    .shift_en(shift_en), .sout(lsb_sout), .sout_valid(lsb_sout_valid), .busy(lsb_busy),
    .done(lsb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic lv, input logic [7:0] d, input logic se);
    rst        = r;
    load_valid = lv;
    din        = d;
    shift_en   = se;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; load_valid = 1'b0; din = 8'h00; shift_en = 1'b0;
    step();
    step();
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("reset sout", sout, 0);
    checkOutput("reset lsb sout", lsb_sout, 1);
    checkOutput("reset sout_valid", sout_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset load_ready", load_ready, 1);

    // C1 single word, both bit orders
    seq_msb = 8'hC1;
    seq_lsb = 8'h83;
    step();
    applyStimulus(0, 1, 8'hC1, 1);
    checkOutput("t1 ready", load_ready, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      applyStimulus(0, 0, 8'h00, 1);
      checkOutput($sformatf("t1 sout c%0d", k), sout, seq_msb[8-k]);
      checkOutput($sformatf("t1 lsb sout c%0d", k), lsb_sout, seq_lsb[8-k]);
      checkOutput($sformatf("t1 valid c%0d", k), sout_valid, 1);
      checkOutput($sformatf("t1 busy c%0d", k), busy, 1);
      checkOutput($sformatf("t1 done c%0d", k), done, 0);
    end
    step();
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t1 done c9", done, 1);
    checkOutput("t1 lsb done c9", lsb_done, 1);
    checkOutput("t1 sout idle c9", sout, 0);
    checkOutput("t1 lsb sout idle c9", lsb_sout, 1);
    checkOutput("t1 valid c9", sout_valid, 0);
    checkOutput("t1 ready c9", load_ready, 1);
    step();
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t1 done c10", done, 0);

    // back-to-back FF then 00
    step();
    applyStimulus(0, 1, 8'hFF, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      applyStimulus(0, (k <= 8), 8'h00, 1);
      checkOutput($sformatf("t2 valid c%0d", k), sout_valid, 1);
      checkOutput($sformatf("t2 sout c%0d", k), sout, (k <= 8));
      checkOutput($sformatf("t2 lsb sout c%0d", k), lsb_sout, (k <= 8));
      checkOutput($sformatf("t2 ready c%0d", k), load_ready, (k == 8 || k == 16));
      checkOutput($sformatf("t2 done c%0d", k), done, (k == 9));
    end
    step();
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t2 done c17", done, 1);
    checkOutput("t2 valid c17", sout_valid, 0);

    // shift_en every third cycle, A5
    word = 8'hA5;
    step();
    applyStimulus(0, 1, 8'hA5, 0);
    for (int c = 1; c <= 24; c++) begin
      step();
      applyStimulus(0, 0, 8'h00, (c % 3 == 0));
      checkOutput($sformatf("t3 sout c%0d", c), sout, word[7-(c-1)/3]);
      checkOutput($sformatf("t3 lsb sout c%0d", c), lsb_sout, word[(c-1)/3]);
      checkOutput($sformatf("t3 valid c%0d", c), sout_valid, 1);
      checkOutput($sformatf("t3 done c%0d", c), done, 0);
    end
    step();
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("t3 done c25", done, 1);
    checkOutput("t3 valid c25", sout_valid, 0);
    step();
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("t3 done c26", done, 0);
    checkOutput("t3 valid c26", sout_valid, 0);

    // load attempts mid-word are ignored
    step();
    applyStimulus(0, 1, 8'hC1, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      applyStimulus(0, (k < 8), 8'h3C, 1);
      checkOutput($sformatf("t4 sout c%0d", k), sout, seq_msb[8-k]);
      checkOutput($sformatf("t4 ready c%0d", k), load_ready, (k == 8));
    end
    step();
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t4 done c9", done, 1);
    checkOutput("t4 valid c9", sout_valid, 0);

    // reset during bit 4, with a simultaneous load attempt
    step();
    applyStimulus(0, 1, 8'hC1, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      applyStimulus(0, 0, 8'h00, 1);
      checkOutput($sformatf("t5 sout c%0d", k), sout, seq_msb[8-k]);
    end
    step();
    applyStimulus(1, 1, 8'h3C, 1);
    checkOutput("t5 sout bit4", sout, seq_msb[3]);
    step();
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t5 sout after rst", sout, 0);
    checkOutput("t5 lsb sout after rst", lsb_sout, 1);
    checkOutput("t5 valid after rst", sout_valid, 0);
    checkOutput("t5 done after rst", done, 0);
    checkOutput("t5 ready after rst", load_ready, 1);
    step();
    applyStimulus(0, 1, 8'hA5, 1);
    checkOutput("t5 done later", done, 0);
    checkOutput("t5 valid later", sout_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      applyStimulus(0, 0, 8'h00, 1);
      checkOutput($sformatf("t5 reload sout c%0d", k), sout, word[8-k]);
      checkOutput($sformatf("t5 reload lsb sout c%0d", k), lsb_sout, word[k-1]);
    end
    step();
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t5 reload done", done, 1);

    // reset wins over a load offered in IDLE
    step();
    applyStimulus(1, 1, 8'hFF, 1);
    step();
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t6 valid", sout_valid, 0);
    checkOutput("t6 sout", sout, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
